// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one UART transmitter among NUM_REQ
//               requesters, with an optional ID header byte per message.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    NUM_REQ    = 4,
    parameter bit                    SEND_ID    = 1'b1,
    parameter logic [DATA_WIDTH-1:0] ID_BASE    = 8'h30
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         txData,
    output logic                          txStartN,
    input  logic                          TxReady,
    output logic                          busy
);

    localparam int         IDX_W     = $clog2(NUM_REQ);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT_TX = 2'd2;

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_rrPtr;
    logic                  r_hdrPend;
    logic [DATA_WIDTH-1:0] r_capData;
    logic [DATA_WIDTH-1:0] r_txData;
    logic [NUM_REQ-1:0]    r_gnt;
    logic [NUM_REQ-1:0]    r_done;

    logic [1:0]            w_stateNext;
    logic                  w_found;
    logic [IDX_W-1:0]      w_winner;
    logic [IDX_W-1:0]      w_cand;
    logic                  w_grant;
    logic                  w_nextByte;
    logic                  w_finish;
    logic [NUM_REQ-1:0]    w_gntOneHot;
    logic [NUM_REQ-1:0]    w_doneOneHot;
    logic [DATA_WIDTH-1:0] w_header;
    logic [DATA_WIDTH-1:0] w_reqBytes [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_reqBytes[g] = reqData[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Search starts just after the last winner so it drops to lowest priority.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_rrPtr) + k) % NUM_REQ);
            if (!w_found && req[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    assign w_header = ID_BASE + DATA_WIDTH'(w_winner);

    always_comb begin
        w_stateNext  = r_state;
        w_grant      = 1'b0;
        w_nextByte   = 1'b0;
        w_finish     = 1'b0;
        w_gntOneHot  = '0;
        w_doneOneHot = '0;
        case (r_state)
            S_IDLE: begin
                if (TxReady && w_found) begin
                    w_grant               = 1'b1;
                    w_gntOneHot[w_winner] = 1'b1;
                    w_stateNext           = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Hold the strobe until the transmitter has visibly accepted it.
                if (!TxReady) w_stateNext = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (TxReady) begin
                    if (r_hdrPend) begin
                        w_nextByte  = 1'b1;
                        w_stateNext = S_LAUNCH;
                    end else begin
                        w_finish              = 1'b1;
                        w_doneOneHot[r_rrPtr] = 1'b1;
                        w_stateNext           = S_IDLE;
                    end
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rrPtr   <= IDX_W'(NUM_REQ - 1);
            r_hdrPend <= 1'b0;
            r_capData <= '0;
            r_txData  <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
        end else begin
            r_state <= w_stateNext;
            r_gnt   <= w_gntOneHot;
            r_done  <= w_doneOneHot;
            if (w_grant) begin
                r_rrPtr   <= w_winner;
                r_capData <= w_reqBytes[w_winner];
                if (SEND_ID) begin
                    r_txData  <= w_header;
                    r_hdrPend <= 1'b1;
                end else begin
                    r_txData  <= w_reqBytes[w_winner];
                end
            end
            if (w_nextByte) begin
                r_hdrPend <= 1'b0;
                r_txData  <= r_capData;
            end
            if (w_finish) r_hdrPend <= 1'b0;
        end
    end

    assign gnt      = r_gnt;
    assign done     = r_done;
    assign txData   = r_txData;
    assign txStartN = (r_state != S_LAUNCH);
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire
